mem_sys: RTL and testbench

- Memory subsystem directly downstream of the CPU bus.
- Consumes the CPU's rd/wr/addr and sources or sinks its 8-bit data.
- Decodes the 13-bit address into a ROM region (program) and a RAM region (data), with registered read return and edge-qualified writes.
- Contains a boot loader FSM that streams the program image into ROM before releasing the CPU.

---
 rtl/mem_sys_pkg.sv | 28 ++
 rtl/mem_sys_loader.sv | 78 +++++++
 rtl/mem_sys.sv | 151 +++++++++++++++
 tb/tb_mem_sys.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sys_pkg.sv
// Shared definitions for the memory subsystem: region defaults, loader
// states, error-source codes and a saturating counter helper.
package mem_sys_pkg;

  localparam int unsigned ROM_AW_DEF   = 12;
  localparam int unsigned RAM_AW_DEF   = 11;
  localparam logic [12:0] RAM_BASE_DEF = 13'h1800;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } load_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_ROM_WR,
    ERR_UNMAPPED,
    ERR_RD_WR_CONFLICT,
    ERR_LOAD_OVF,
    ERR_PARITY
  } err_src_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_sys_loader.sv
// Boot loader: streams the program image into ROM, holds the CPU in reset
// until the image is complete (or truncated by pointer overflow).
module mem_loader
  import mem_sys_pkg::*;
#(
  parameter int unsigned ROM_AW = ROM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_waddr,
  output logic [7:0]        rom_wdata,
  output logic              load_ovf
);

  load_state_e       state_q, state_d;
  logic [ROM_AW-1:0] ptr_q, ptr_d;

  // State and pointer registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state, pointer advance and ROM write strobe.
  // NOTE: every output gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rom_we   = 1'b0;
    load_ovf = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          rom_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (load_last) begin
            state_d = RUN;
          end else if (ptr_q == '1) begin
            // Image does not fit: keep what was written, flag it, run anyway.
            state_d  = RUN;
            load_ovf = 1'b1;
          end
        end
      end
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign load_ready = (state_q == LOAD);
  assign cpu_hold   = (state_q != RUN);
  assign boot_done  = (state_q == RUN);
  assign rom_waddr  = ptr_q;
  assign rom_wdata  = load_byte;

endmodule

// File: rtl/mem_sys.sv
// Memory subsystem: ROM/RAM decode, registered reads, edge-qualified
// writes, sticky error flag and saturating illegal-access counter.
// Optional build macro MEM_PARITY_EN adds an even-parity bit to each RAM word.
module mem_sys
  import mem_sys_pkg::*;
#(
  parameter int unsigned ROM_AW   = ROM_AW_DEF,
  parameter int unsigned RAM_AW   = RAM_AW_DEF,
  parameter logic [12:0] RAM_BASE = RAM_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [12:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic        err,
  output logic [7:0]  err_cnt
);

`ifdef MEM_PARITY_EN
  localparam int unsigned RAM_W = 9;
`else
  localparam int unsigned RAM_W = 8;
`endif
  localparam int unsigned ROM_SIZE = 1 << ROM_AW;
  localparam int unsigned RAM_SIZE = 1 << RAM_AW;

  logic [7:0]       rom_mem [ROM_SIZE];
  logic [RAM_W-1:0] ram_mem [RAM_SIZE];

  logic              rom_we, load_ovf;
  logic [ROM_AW-1:0] rom_waddr;
  logic [7:0]        rom_wdata;

  mem_loader #(.ROM_AW(ROM_AW)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_hold   (cpu_hold),
    .boot_done  (boot_done),
    .rom_we     (rom_we),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .load_ovf   (load_ovf)
  );

  logic       rd_q, wr_q, data_oe_q, err_q;
  logic       data_oe_d, err_d;
  logic [7:0] data_out_q, data_out_d, err_cnt_q, err_cnt_d;

  logic              run, in_rom, in_ram, rd_rise, wr_rise, conflict_rise;
  logic              cpu_rd, cpu_wr, ram_we, par_bad;
  logic [31:0]       addr_w;
  logic [RAM_AW-1:0] ram_idx;
  logic [RAM_W-1:0]  ram_rword, ram_wword;
  logic [7:0]        rd_data;
  err_src_e          err_src;

  assign run = boot_done;

  // Address decode, read mux and error classification.
  always_comb begin
    addr_w    = 32'(addr);
    in_rom    = addr_w < ROM_SIZE;
    in_ram    = (addr_w >= 32'(RAM_BASE)) && (addr_w < 32'(RAM_BASE) + RAM_SIZE);
    ram_idx   = RAM_AW'(addr - RAM_BASE);
    ram_rword = ram_mem[ram_idx];
`ifdef MEM_PARITY_EN
    ram_wword = {^data_in, data_in};
    par_bad   = ^ram_rword;
`else
    ram_wword = data_in;
    par_bad   = 1'b0;
`endif
    rd_data = 8'h00;
    if (in_rom)      rd_data = rom_mem[ROM_AW'(addr)];
    else if (in_ram) rd_data = ram_rword[7:0];

    rd_rise       = rd && !rd_q;
    wr_rise       = wr && !wr_q;
    conflict_rise = rd && wr && !(rd_q && wr_q);
    cpu_rd        = run && rd && !wr;
    cpu_wr        = run && wr_rise && !rd;
    ram_we        = cpu_wr && in_ram;

    err_src = ERR_NONE;
    if (conflict_rise)                                  err_src = ERR_RD_WR_CONFLICT;
    else if (cpu_rd && rd_rise && !in_rom && !in_ram)   err_src = ERR_UNMAPPED;
    else if (cpu_wr && in_rom)                          err_src = ERR_ROM_WR;
    else if (cpu_wr && !in_ram)                         err_src = ERR_UNMAPPED;
    else if (cpu_rd && rd_rise && in_ram && par_bad)    err_src = ERR_PARITY;
    else if (load_ovf)                                  err_src = ERR_LOAD_OVF;
  end

  // Next values for the read return and error registers.
  always_comb begin
    data_oe_d  = cpu_rd;
    data_out_d = cpu_rd ? rd_data : data_out_q;
    err_d      = err_q || (err_src != ERR_NONE);
    err_cnt_d  = err_cnt_q;
    if (err_src inside {ERR_ROM_WR, ERR_UNMAPPED, ERR_RD_WR_CONFLICT, ERR_PARITY})
      err_cnt_d = sat_inc(err_cnt_q);
  end

  // Strobe history, read return and error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= 8'h00;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      rd_q       <= rd;
      wr_q       <= wr;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Memory arrays.
  // NOTE: storage has no reset; contents are defined only by loads and
  // writes, which keeps the arrays mappable onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (rom_we) rom_mem[rom_waddr] <= rom_wdata;
    if (ram_we) ram_mem[ram_idx]   <= ram_wword;
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mem_sys.sv
// Directed self-checking bench for mem_sys: boot load, reads, writes,
// error accounting, loader overflow and mid-load reset.
module tb_mem_sys;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [12:0] addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_ready, cpu_hold, boot_done, err;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_sys dut (
    .clk        (clk),
    .rst        (rst),
    .rd         (rd),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_hold   (cpu_hold),
    .boot_done  (boot_done),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(2);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data_out got=%h exp=00", data_out); end
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL rst_data_oe got=%b exp=0", data_oe); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_load_ready got=%b exp=0", load_ready); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
    total++; if (boot_done !== 1'b0) begin bad++; $display("FAIL rst_boot_done got=%b exp=0", boot_done); end
    total++; if ({err, err_cnt} !== 9'h000) begin bad++; $display("FAIL rst_err got=%b/%h exp=0/00", err, err_cnt); end
    rst = 1'b1;
    rd = 1'b1; addr = 13'h0000;
    tick();
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL idle_rd_oe got=%b exp=0", data_oe); end
    rd = 1'b0;
    tick();
  endtask

  task automatic test_boot_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    total++; if ({load_ready, cpu_hold, boot_done} !== 3'b110) begin bad++; $display("FAIL load_state got=%b exp=110", {load_ready, cpu_hold, boot_done}); end
    load_valid = 1'b1;
    load_byte = 8'h11; tick();
    load_byte = 8'h22; tick();
    load_byte = 8'h33; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    total++; if ({load_ready, cpu_hold, boot_done} !== 3'b001) begin bad++; $display("FAIL run_state got=%b exp=001", {load_ready, cpu_hold, boot_done}); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL load_err got=%b exp=0", err); end
    rd = 1'b1; addr = 13'h0001;
    tick();
    total++; if (data_out !== 8'h22) begin bad++; $display("FAIL rom_rd1 got=%h exp=22", data_out); end
    total++; if (data_oe !== 1'b1) begin bad++; $display("FAIL rom_rd1_oe got=%b exp=1", data_oe); end
    rd = 1'b0;
    tick();
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL oe_drop got=%b exp=0", data_oe); end
  endtask

  task automatic test_ram_write;
    wr = 1'b1; addr = 13'h1805; data_in = 8'hA5;
    tick();
    data_in = 8'h3C;  // a repeated write would store this instead
    tick(3);
    wr = 1'b0;
    tick();
    rd = 1'b1;
    tick();
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL ram_rd got=%h exp=a5", data_out); end
    total++; if ({err, err_cnt} !== 9'h000) begin bad++; $display("FAIL ram_wr_err got=%b/%h exp=0/00", err, err_cnt); end
    rd = 1'b0;
    tick();
  endtask

  task automatic test_rom_write;
    wr = 1'b1; addr = 13'h0002; data_in = 8'hFF;
    tick();
    wr = 1'b0;
    tick();
    total++; if ({err, err_cnt} !== {1'b1, 8'h01}) begin bad++; $display("FAIL rom_wr_err got=%b/%h exp=1/01", err, err_cnt); end
    rd = 1'b1;
    tick();
    total++; if (data_out !== 8'h33) begin bad++; $display("FAIL rom_unchanged got=%h exp=33", data_out); end
    rd = 1'b0;
    tick();
  endtask

  task automatic test_conflict;
    wr = 1'b1; addr = 13'h1800; data_in = 8'h5C;
    tick();
    wr = 1'b0;
    tick();
    rd = 1'b1; wr = 1'b1; data_in = 8'h77;
    tick();
    total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL conflict_oe got=%b exp=0", data_oe); end
    tick();
    total++; if (err_cnt !== 8'h02) begin bad++; $display("FAIL conflict_cnt got=%h exp=02", err_cnt); end
    rd = 1'b0; wr = 1'b0;
    tick();
    rd = 1'b1;
    tick();
    total++; if (data_out !== 8'h5C) begin bad++; $display("FAIL conflict_ram got=%h exp=5c", data_out); end
    rd = 1'b0;
    tick();
  endtask

  task automatic test_unmapped;
    rd = 1'b1; addr = 13'h1000;
    tick(3);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL unmap_rd got=%h exp=00", data_out); end
    total++; if (err_cnt !== 8'h03) begin bad++; $display("FAIL unmap_rd_cnt got=%h exp=03", err_cnt); end
    rd = 1'b0;
    tick();
    wr = 1'b1; addr = 13'h17FF; data_in = 8'h01;
    tick();
    wr = 1'b0;
    tick();
    total++; if (err_cnt !== 8'h04) begin bad++; $display("FAIL unmap_wr_cnt got=%h exp=04", err_cnt); end
    wr = 1'b1; addr = 13'h1FFF; data_in = 8'h99;
    tick();
    wr = 1'b0;
    tick();
    rd = 1'b1;
    tick();
    total++; if (data_out !== 8'h99) begin bad++; $display("FAIL ram_top got=%h exp=99", data_out); end
    total++; if (err_cnt !== 8'h04) begin bad++; $display("FAIL ram_top_cnt got=%h exp=04", err_cnt); end
    rd = 1'b0;
    tick();
  endtask

  task automatic test_start_in_run;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    total++; if ({load_ready, boot_done} !== 2'b01) begin bad++; $display("FAIL start_in_run got=%b exp=01", {load_ready, boot_done}); end
    rd = 1'b1; addr = 13'h0000;
    tick();
    total++; if (data_out !== 8'h11) begin bad++; $display("FAIL rom0_kept got=%h exp=11", data_out); end
    rd = 1'b0;
    tick();
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity;
    wr = 1'b1; addr = 13'h1810; data_in = 8'h3C;
    tick();
    wr = 1'b0;
    tick();
    dut.ram_mem[16][8] = ~dut.ram_mem[16][8];
    rd = 1'b1;
    tick(2);
    total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL parity_data got=%h exp=3c", data_out); end
    total++; if (err_cnt !== 8'h05) begin bad++; $display("FAIL parity_cnt got=%h exp=05", err_cnt); end
    rd = 1'b0;
    tick();
  endtask
`endif

  task automatic test_overflow;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    // Abort a load half-way with reset.
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_byte = 8'hEE; tick(2);
    rst = 1'b0; #1;
    total++; if ({load_ready, cpu_hold, boot_done} !== 3'b010) begin bad++; $display("FAIL midload_rst got=%b exp=010", {load_ready, cpu_hold, boot_done}); end
    load_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++; if ({err, err_cnt} !== 9'h000) begin bad++; $display("FAIL ovf_pre_err got=%b/%h exp=0/00", err, err_cnt); end
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i <= 4096; i++) begin
      load_byte = 8'(i * 7 + 3);
      if (i == 4095) begin
        total++; if ({load_ready, err} !== 2'b10) begin bad++; $display("FAIL ovf_last_slot got=%b exp=10", {load_ready, err}); end
      end
      tick();
    end
    load_valid = 1'b0;
    total++; if ({load_ready, cpu_hold, boot_done} !== 3'b001) begin bad++; $display("FAIL ovf_state got=%b exp=001", {load_ready, cpu_hold, boot_done}); end
    total++; if ({err, err_cnt} !== {1'b1, 8'h00}) begin bad++; $display("FAIL ovf_err got=%b/%h exp=1/00", err, err_cnt); end
    rd = 1'b1; addr = 13'h0000;
    tick();
    total++; if (data_out !== 8'h03) begin bad++; $display("FAIL ovf_rom0 got=%h exp=03", data_out); end
    addr = 13'h0FFF;
    tick();
    total++; if (data_out !== 8'hFC) begin bad++; $display("FAIL ovf_romtop got=%h exp=fc", data_out); end
    rd = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_boot_load();
    test_ram_write();
    test_rom_write();
    test_conflict();
    test_unmapped();
    test_start_in_run();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
